// File: rtl/rpn_pkg.sv
// Shared constants for the RPN execution unit: opcodes, error codes and FSM encoding.
package rpn_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD = 3'd0;
    localparam opcode_t OP_SUB = 3'd1;
    localparam opcode_t OP_MUL = 3'd2;
    localparam opcode_t OP_AND = 3'd3;
    localparam opcode_t OP_OR  = 3'd4;
    localparam opcode_t OP_XOR = 3'd5;
    localparam opcode_t OP_EQU = 3'd6;
    localparam opcode_t OP_CLR = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_EQU   = 2'd3;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_POP_B  = 4'd1;
    localparam logic [3:0] ST_POP_A  = 4'd2;
    localparam logic [3:0] ST_EXEC   = 4'd3;
    localparam logic [3:0] ST_PUSH   = 4'd4;
    localparam logic [3:0] ST_POP_R  = 4'd5;
    localparam logic [3:0] ST_RESULT = 4'd6;
    localparam logic [3:0] ST_DRAIN  = 4'd7;
    localparam logic [3:0] ST_ERROR  = 4'd8;

endpackage

// File: rtl/rpn_exec_if.sv
// Token, stack and result handshakes of the RPN execution unit.
interface rpn_exec_if #(
    parameter int W = 32
);
    // Every *_STB/*_ACK pair transfers on a cycle where both are high; a
    // strobe is held with stable data until acknowledged. POP_ACK alone is a
    // one-cycle command: POP_DAT is the top now, the stack drops it next edge.
    logic         TOK_STB;
    logic         TOK_OP;
    logic [W-1:0] TOK_DAT;
    logic         TOK_ACK;
    logic         PUSH_STB;
    logic [W-1:0] PUSH_DAT;
    logic         PUSH_ACK;
    logic [W-1:0] POP_DAT;
    logic         POP_ACK;
    logic         RES_STB;
    logic [W-1:0] RES_DAT;
    logic         RES_ACK;

    modport master (
        input  TOK_STB, TOK_OP, TOK_DAT, PUSH_ACK, POP_DAT, RES_ACK,
        output TOK_ACK, PUSH_STB, PUSH_DAT, POP_ACK, RES_STB, RES_DAT
    );

    modport slave (
        output TOK_STB, TOK_OP, TOK_DAT, PUSH_ACK, POP_DAT, RES_ACK,
        input  TOK_ACK, PUSH_STB, PUSH_DAT, POP_ACK, RES_STB, RES_DAT
    );

endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU: unsigned modulo-2^W arithmetic and bitwise ops, A is the deeper operand.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  opcode_t      op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_exec.sv
// RPN execution unit: consumes tokens, masters the operand stack, and delivers EQU results.
module rpn_exec
    import rpn_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    rpn_exec_if.master               bus,
    output logic                     ERR,
    output logic [1:0]               ERR_CODE,
    output logic [$clog2(DEPTH):0]   DEPTH_O,
    output logic [3:0]               dbg_state
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    logic [3:0]    state;
    logic [DW-1:0] depth;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  push_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  alu_y;
    opcode_t       op_q;
    opcode_t       tok_opc;
    logic          tok_fire;
    logic          push_fire;

    assign tok_opc   = bus.TOK_DAT[2:0];
    assign tok_fire  = bus.TOK_STB & bus.TOK_ACK;
    assign push_fire = bus.PUSH_STB & bus.PUSH_ACK;

    assign bus.TOK_ACK  = !RST && (state == ST_IDLE || state == ST_ERROR);
    assign bus.PUSH_STB = (state == ST_PUSH);
    assign bus.PUSH_DAT = push_q;
    // The stack gives push priority, so pops only come from states that never push.
    assign bus.POP_ACK  = (state == ST_POP_B) || (state == ST_POP_A) || (state == ST_POP_R) ||
                          (state == ST_DRAIN && depth != '0);
    assign bus.RES_STB  = (state == ST_RESULT);
    assign bus.RES_DAT  = res_q;

    assign DEPTH_O   = depth;
    assign dbg_state = state;

    rpn_alu #(.W(W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            depth    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            push_q   <= '0;
            res_q    <= '0;
            op_q     <= OP_ADD;
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
        end else begin
            if (push_fire) begin
                depth <= depth + DW'(1);
            end else if (bus.POP_ACK) begin
                depth <= depth - DW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (tok_fire) begin
                        if (!bus.TOK_OP) begin
                            if (depth == DEPTH_FULL) begin
                                state    <= ST_ERROR;
                                ERR      <= 1'b1;
                                ERR_CODE <= ERR_OVER;
                            end else begin
                                push_q <= bus.TOK_DAT;
                                state  <= ST_PUSH;
                            end
                        end else begin
                            op_q <= tok_opc;
                            case (tok_opc)
                                OP_EQU: begin
                                    if (depth != DW'(1)) begin
                                        state    <= ST_ERROR;
                                        ERR      <= 1'b1;
                                        ERR_CODE <= ERR_EQU;
                                    end else begin
                                        state <= ST_POP_R;
                                    end
                                end
                                OP_CLR: state <= ST_DRAIN;
                                default: begin
                                    if (depth < DW'(2)) begin
                                        state    <= ST_ERROR;
                                        ERR      <= 1'b1;
                                        ERR_CODE <= ERR_UNDER;
                                    end else begin
                                        state <= ST_POP_B;
                                    end
                                end
                            endcase
                        end
                    end
                end
                // B is on top, so it is popped first and A is uncovered next.
                ST_POP_B: begin
                    b_q   <= bus.POP_DAT;
                    state <= ST_POP_A;
                end
                ST_POP_A: begin
                    a_q   <= bus.POP_DAT;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    push_q <= alu_y;
                    state  <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (bus.PUSH_ACK) state <= ST_IDLE;
                end
                ST_POP_R: begin
                    res_q <= bus.POP_DAT;
                    state <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (bus.RES_ACK) state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (depth == '0) begin
                        ERR      <= 1'b0;
                        ERR_CODE <= ERR_NONE;
                        state    <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (tok_fire && bus.TOK_OP && tok_opc == OP_CLR) state <= ST_DRAIN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_exec.sv
// Directed bench for rpn_exec with a behavioural stack and a result scoreboard.
`timescale 1ns/1ps
module tb_rpn_exec;
    import rpn_pkg::*;

    localparam int W        = 32;
    localparam int DEPTH    = 16;
    localparam int DW       = $clog2(DEPTH) + 1;
    localparam int RES_HOLD = 3;
    localparam int TIMEOUT  = 200;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ERR;
    logic [1:0]    ERR_CODE;
    logic [DW-1:0] DEPTH_O;
    logic [3:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    int hold     = 0;

    rpn_exec_if #(.W(W)) bus ();

    rpn_exec #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE),
        .DEPTH_O   (DEPTH_O),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    // ---------------- stack model ----------------
    logic [W-1:0] stk [DEPTH];
    int sp;

    assign bus.PUSH_ACK = bus.PUSH_STB;
    assign bus.POP_DAT  = (sp > 0) ? stk[sp-1] : '0;

    always @(posedge CLK) begin
        if (RST) begin
            sp <= 0;
        end else if (bus.PUSH_STB && sp < DEPTH) begin
            stk[sp] <= bus.PUSH_DAT;
            sp      <= sp + 1;
        end else if (bus.POP_ACK && sp > 0) begin
            sp <= sp - 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bus.RES_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hold        = 0;
                bus.RES_ACK = 1'b0;
            end else begin
                if (bus.PUSH_STB) push_cnt++;
                if (bus.POP_ACK)  pop_cnt++;
                if (bus.PUSH_STB && bus.POP_ACK) begin
                    failures++;
                    $display("FAIL push_pop_overlap: got both high, expected at most one");
                end
                if (bus.RES_ACK) begin
                    bus.RES_ACK = 1'b0;
                    hold        = 0;
                    check("res_release", W'(bus.RES_STB), W'(0));
                end else if (bus.RES_STB) begin
                    hold++;
                    if (hold == RES_HOLD) begin
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL res_unexpected: got RES_DAT %0h, expected no result", bus.RES_DAT);
                        end else begin
                            check("res_dat", bus.RES_DAT, exp_q.pop_front());
                        end
                        bus.RES_ACK = 1'b1;
                    end
                end else if (hold > 0) begin
                    failures++;
                    $display("FAIL res_hold: got RES_STB dropped after %0d cycles, expected held until ack", hold);
                    hold = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the token was accepted.
    task automatic send_tok(input logic op, input logic [W-1:0] dat);
        int n;
        bus.TOK_STB = 1'b1;
        bus.TOK_OP  = op;
        bus.TOK_DAT = dat;
        n = 0;
        while (!bus.TOK_ACK && n < TIMEOUT) begin
            @(negedge CLK);
            n++;
        end
        if (n >= TIMEOUT) begin
            failures++;
            $display("FAIL tok_timeout: got no TOK_ACK in %0d cycles, expected acceptance", TIMEOUT);
        end
        @(negedge CLK);
        bus.TOK_STB = 1'b0;
    endtask

    task automatic send_op(input opcode_t op);
        send_tok(1'b1, W'(op));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(dbg_state == ST_IDLE && exp_q.size() == 0 && hold == 0) && n < TIMEOUT) begin
            @(negedge CLK);
            n++;
        end
        if (n >= TIMEOUT) begin
            failures++;
            $display("FAIL idle_timeout: got state %0d, expected IDLE within %0d cycles", dbg_state, TIMEOUT);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    opcode_t      vo [6];
    logic [W-1:0] ve [6];
    int base;

    initial begin
        bus.TOK_STB = 1'b0;
        bus.TOK_OP  = 1'b0;
        bus.TOK_DAT = '0;
        va[0] = 32'hF0F0_1234; vb[0] = 32'h0FF0_5678; vo[0] = OP_AND; ve[0] = 32'h00F0_1230;
        va[1] = 32'hF0F0_1234; vb[1] = 32'h0FF0_5678; vo[1] = OP_OR;  ve[1] = 32'hFFF0_567C;
        va[2] = 32'hF0F0_1234; vb[2] = 32'h0FF0_5678; vo[2] = OP_XOR; ve[2] = 32'hFF00_444C;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0002; vo[3] = OP_ADD; ve[3] = 32'h0000_0001;
        va[4] = 32'hFFFF_FFFF; vb[4] = 32'h0000_0002; vo[4] = OP_MUL; ve[4] = 32'hFFFF_FFFE;
        va[5] = 32'h0000_0064; vb[5] = 32'h0000_001E; vo[5] = OP_SUB; ve[5] = 32'h0000_0046;

        repeat (3) @(negedge CLK);
        check("rst_tok_ack",  W'(bus.TOK_ACK),  W'(0));
        check("rst_push_stb", W'(bus.PUSH_STB), W'(0));
        check("rst_pop_ack",  W'(bus.POP_ACK),  W'(0));
        check("rst_res_stb",  W'(bus.RES_STB),  W'(0));
        check("rst_err",      W'(ERR),          W'(0));
        check("rst_depth",    W'(DEPTH_O),      W'(0));
        RST = 1'b0;
        @(negedge CLK);
        check("idle_tok_ack", W'(bus.TOK_ACK), W'(1));

        // 3 4 ADD EQU
        send_tok(1'b0, 32'd3);
        check("opnd_push_next", W'(bus.PUSH_STB), W'(1));
        send_tok(1'b0, 32'd4);
        send_op(OP_ADD);
        check("binop_pop_next", W'(bus.POP_ACK), W'(1));
        exp_q.push_back(32'd7);
        send_op(OP_EQU);
        check("equ_pop_next", W'(bus.POP_ACK), W'(1));
        wait_idle();
        check("add_depth_end", W'(DEPTH_O), W'(0));

        // 10 3 SUB 5 MUL EQU
        send_tok(1'b0, 32'd10);
        send_tok(1'b0, 32'd3);
        send_op(OP_SUB);
        send_tok(1'b0, 32'd5);
        send_op(OP_MUL);
        exp_q.push_back(32'd35);
        send_op(OP_EQU);
        wait_idle();

        // 3 10 SUB EQU wraps
        send_tok(1'b0, 32'd3);
        send_tok(1'b0, 32'd10);
        send_op(OP_SUB);
        exp_q.push_back(32'hFFFF_FFF9);
        send_op(OP_EQU);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            send_tok(1'b0, va[i]);
            send_tok(1'b0, vb[i]);
            send_op(vo[i]);
            exp_q.push_back(ve[i]);
            send_op(OP_EQU);
            wait_idle();
        end
        check("table_depth_end", W'(DEPTH_O), W'(0));

        // underflow, tokens ignored, CLR recovery
        base = push_cnt;
        send_op(OP_ADD);
        check("under_err",  W'(ERR),      W'(1));
        check("under_code", W'(ERR_CODE), W'(ERR_UNDER));
        send_tok(1'b0, 32'd5);
        send_tok(1'b0, 32'd6);
        repeat (2) @(negedge CLK);
        check("under_ignored_push", W'(push_cnt - base), W'(0));
        check("under_depth",        W'(DEPTH_O),         W'(0));
        send_op(OP_CLR);
        wait_idle();
        check("under_clr_err",   W'(ERR),      W'(0));
        check("under_clr_code",  W'(ERR_CODE), W'(ERR_NONE));
        check("under_clr_depth", W'(DEPTH_O),  W'(0));

        // overflow at 17 operands, then drain
        base = push_cnt;
        for (int i = 0; i < DEPTH; i++) send_tok(1'b0, W'(i + 1));
        repeat (2) @(negedge CLK);
        check("full_depth",  W'(DEPTH_O),         W'(DEPTH));
        check("full_pushes", W'(push_cnt - base), W'(DEPTH));
        send_tok(1'b0, 32'd17);
        repeat (2) @(negedge CLK);
        check("over_code",   W'(ERR_CODE),        W'(ERR_OVER));
        check("over_err",    W'(ERR),             W'(1));
        check("over_nopush", W'(push_cnt - base), W'(DEPTH));
        check("over_depth",  W'(DEPTH_O),         W'(DEPTH));
        base = pop_cnt;
        send_op(OP_CLR);
        wait_idle();
        check("drain_pops",  W'(pop_cnt - base), W'(DEPTH));
        check("drain_depth", W'(DEPTH_O),        W'(0));
        check("drain_sp",    W'(sp),             W'(0));
        check("drain_err",   W'(ERR),            W'(0));

        // EQU with depth 2
        send_tok(1'b0, 32'd1);
        send_tok(1'b0, 32'd2);
        send_op(OP_EQU);
        repeat (5) @(negedge CLK);
        check("equ_code",  W'(ERR_CODE), W'(ERR_EQU));
        check("equ_depth", W'(DEPTH_O),  W'(2));
        send_op(OP_CLR);
        wait_idle();
        check("equ_clr_depth", W'(DEPTH_O), W'(0));

        // reset while in EXEC
        send_tok(1'b0, 32'd6);
        send_tok(1'b0, 32'd7);
        send_op(OP_MUL);
        repeat (2) @(negedge CLK);
        check("pre_rst_exec", W'(dbg_state), W'(ST_EXEC));
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_state",    W'(dbg_state),    W'(ST_IDLE));
        check("mid_rst_tok_ack",  W'(bus.TOK_ACK),  W'(0));
        check("mid_rst_push_stb", W'(bus.PUSH_STB), W'(0));
        check("mid_rst_push_dat", bus.PUSH_DAT,     W'(0));
        check("mid_rst_pop_ack",  W'(bus.POP_ACK),  W'(0));
        check("mid_rst_res_dat",  bus.RES_DAT,      W'(0));
        check("mid_rst_depth",    W'(DEPTH_O),      W'(0));
        RST = 1'b0;
        @(negedge CLK);

        send_tok(1'b0, 32'd9);
        exp_q.push_back(32'd9);
        send_op(OP_EQU);
        wait_idle();

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rpn_exec.md
# rpn_exec

RPN execution unit for the ONP calculator. It consumes a token stream (operands and operators) from the tokenizer and drives the 16-entry operand `stack` through its push/pop handshakes. Binary operations pop two operands, compute, and push the result; the `EQU` token delivers the final value on a result port. It sits directly upstream of `stack` and is the only master of it.

## Interface
- `W`, 32: data width; must equal the stack data width.
- `DEPTH`, 16: stack capacity; must equal the stack RAM depth.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `TOK_STB` in 1: token valid.
- `TOK_OP` in 1: 1 = operator token (opcode in `TOK_DAT[2:0]`), 0 = operand.
- `TOK_DAT` in W: operand value or opcode.
- `TOK_ACK` out 1: token accepted when `TOK_STB & TOK_ACK`.
- `PUSH_STB` out 1: push request to stack.
- `PUSH_DAT` out W: value to push.
- `PUSH_ACK` in 1: stack accepted push (combinational from stack).
- `POP_DAT` in W: current stack top (combinational from stack).
- `POP_ACK` out 1: one-cycle pulse; stack decrements on the next edge.
- `RES_STB` out 1: result valid.
- `RES_DAT` out W: result value.
- `RES_ACK` in 1: result consumed.
- `ERR` out 1: sticky error flag.
- `ERR_CODE` out 2: 0 none, 1 underflow, 2 overflow, 3 bad `EQU` depth.
- `DEPTH_O` out $clog2(DEPTH)+1: current tracked stack occupancy.

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B, A = deeper operand), 2 MUL (low W bits), 3 AND, 4 OR, 5 XOR, 6 EQU, 7 CLR.
- Arithmetic is unsigned modulo 2^W; no carry or overflow flag.
- The stack has no empty/full outputs, so the occupancy counter `depth` (0..DEPTH) is authoritative. It increments on each accepted push and decrements on each `POP_ACK`.
- The block never asserts `PUSH_STB` and `POP_ACK` in the same cycle, because the stack gives push priority.
- States:
  - IDLE: `TOK_ACK`=1. On acceptance:
    - operand: if `depth==DEPTH` → ERROR(2); else latch to `PUSH_DAT` → PUSH.
    - binary operator: if `depth<2` → ERROR(1); else → POP_B.
    - EQU: if `depth!=1` → ERROR(3); else → POP_R.
    - CLR: → DRAIN.
  - POP_B: B←`POP_DAT`, `POP_ACK`=1 → POP_A.
  - POP_A: A←`POP_DAT`, `POP_ACK`=1 → EXEC.
  - EXEC: `PUSH_DAT`←ALU(A,B,op) → PUSH.
  - PUSH: `PUSH_STB`=1, held until `PUSH_ACK` → IDLE.
  - POP_R: `RES_DAT`←`POP_DAT`, `POP_ACK`=1 → RESULT.
  - RESULT: `RES_STB`=1, held until `RES_ACK` → IDLE.
  - DRAIN: `POP_ACK`=1 while `depth>0`; when `depth==0`, clear ERR/ERR_CODE → IDLE.
  - ERROR: `TOK_ACK`=1; every token except CLR is discarded; CLR → DRAIN.
- An error sets ERR and ERR_CODE. The stack is left untouched until CLR.

## Timing
- Reset values: all outputs 0, state IDLE, depth 0. `TOK_ACK` is forced to 0 while `RST` is high.
- Operand token accepted at cycle t: `PUSH_STB` at t+1; the stack accepts in the same cycle; `TOK_ACK` returns at t+2.
- Binary operator accepted at t: `POP_ACK` at t+1 and t+2, EXEC at t+3, `PUSH_STB` at t+4, IDLE at t+5.
- EQU accepted at t: `POP_ACK` at t+1; `RES_STB` from t+2 until the cycle `RES_ACK` is seen.
- CLR at depth n: n consecutive `POP_ACK` cycles, then IDLE one cycle later.
- `RST` in any state aborts the operation immediately. The stack must be reset by the same `RST`.

## Structure
- Package `rpn_pkg` holds the opcode constants, error codes, and state encoding.
- Sub-module `rpn_alu` is purely combinational: A, B, opcode → W-bit result.
- The FSM, depth counter, and operand registers live in `rpn_exec`.

## Test plan
- Tokens 3, 4, ADD, EQU → `RES_DAT`=7, `RES_STB` held until `RES_ACK`; `DEPTH_O` ends at 0.
- Tokens 10, 3, SUB, 5, MUL, EQU → `RES_DAT`=35; a second run with 3, 10, SUB, EQU → `RES_DAT`=0xFFFFFFF9.
- Single token ADD on an empty stack → ERR=1, ERR_CODE=1; subsequent operands ignored; CLR → ERR=0, `DEPTH_O`=0.
- 17 operand tokens → first 16 pushed; the 17th gives ERR_CODE=2 with no `PUSH_STB`. CLR → exactly 16 `POP_ACK` pulses, then IDLE.
- Tokens 1, 2, EQU → ERR_CODE=3 and no `RES_STB`; `RST` mid-EXEC → all outputs 0 next cycle and `DEPTH_O`=0.
